// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: credit-limited sequential fetch into an in-order
// prefetch FIFO, with redirect flush and in-flight response discard.
module inst_fetch_queue #(
    parameter int PC_W  = 8,
    parameter int INS_W = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req_valid,
    output logic [PC_W-1:0]  imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_rsp_valid,
    input  logic [INS_W-1:0] imem_rsp_data,
    output logic             ins_valid,
    output logic [INS_W-1:0] ins_data,
    output logic [PC_W-1:0]  ins_pc,
    input  logic             ins_ready,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]  rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    logic [PC_W-1:0]  pc_mem_q   [DEPTH];
    logic [INS_W-1:0] data_mem_q [DEPTH];

    logic [CNT_W:0]   credits_used;
    logic             credit_ok;
    logic             req_fire;
    logic             rsp_fire;
    logic             push;
    logic             pop;
    logic [PC_W-1:0]  redirect_pc_aligned;

    // Buffered entries and outstanding requests share one credit pool, so a
    // response always finds a free FIFO slot.
    assign credits_used = {1'b0, count_q} + {1'b0, outstanding_q};
    assign credit_ok    = credits_used < (CNT_W+1)'(DEPTH);

    assign imem_req_valid = !reset && credit_ok;
    assign imem_req_addr  = reset ? '0 : fetch_pc_q;

    assign ins_valid = !reset && (count_q != '0);
    assign ins_data  = reset ? '0 : data_mem_q[rd_ptr_q];
    assign ins_pc    = reset ? '0 : pc_mem_q[rd_ptr_q];

    assign redirect_pc_aligned = {redirect_pc[PC_W-1:2], 2'b00};

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_fire = imem_rsp_valid && !reset;
    assign push     = rsp_fire && (discard_q == '0) && !redirect;
    assign pop      = ins_valid && ins_ready && !redirect;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
        discard_d     = discard_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;

        if (redirect) begin
            fetch_pc_d = redirect_pc_aligned;
            rsp_pc_d   = redirect_pc_aligned;
            count_d    = '0;
            // Everything still in flight after this edge belongs to the old path.
            discard_d  = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + PC_W'(4);
            end
            if (rsp_fire && (discard_q != '0)) begin
                discard_d = discard_q - CNT_W'(1);
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + PC_W'(4);
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= '0;
            rsp_pc_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Storage needs no reset; validity is carried entirely by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
            data_mem_q[wr_ptr_q] <= imem_rsp_data;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && (count_q == CNT_W'(DEPTH))));
    a_rsp_expected: assert property (@(posedge clk) disable iff (reset)
        !(rsp_fire && (outstanding_q == '0)));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: memory model with configurable
// latency/ready pattern, expected instruction stream checked at the output.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic [7:0]  imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        ins_valid;
    logic [31:0] ins_data;
    logic [7:0]  ins_pc;
    logic        ins_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = '0;

    inst_fetch_queue #(.PC_W(8), .INS_W(32), .DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .ins_valid      (ins_valid),
        .ins_data       (ins_data),
        .ins_pc         (ins_pc),
        .ins_ready      (ins_ready),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        int         due;
        int         ep;
    } req_t;

    req_t        pend[$];
    logic [39:0] exp_q[$];
    logic [7:0]  pop_log[$];

    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         epoch = 0;
    int         pops = 0;
    int         lat = 1;
    int         rdy_pat = 0;
    bit         ins_rdy = 1'b1;
    logic [7:0] next_fetch = '0;

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return {8'hC3, a, ~a, a ^ 8'h5A};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset          = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        imem_req_ready = 1'b1;
        ins_ready      = 1'b1;
        redirect       = 1'b0;
        pend.delete();
        exp_q.delete();
        next_fetch = '0;
        epoch++;
        for (int i = 0; i < n; i++) begin
            #1;
            chk("rst_req_valid", imem_req_valid, 0);
            chk("rst_req_addr", imem_req_addr, 0);
            chk("rst_ins_valid", ins_valid, 0);
            chk("rst_ins_data", ins_data, 0);
            chk("rst_ins_pc", ins_pc, 0);
            @(negedge clk);
        end
        reset          = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        ins_ready      = 1'b0;
    endtask

    task automatic cycle(input bit rd = 1'b0, input logic [7:0] rpc = 8'h00);
        bit         accept;
        req_t       r;
        logic [39:0] e;
        @(negedge clk);
        cyc++;
        imem_req_ready = (rdy_pat == 0) ? 1'b1 : ((rdy_pat == 1) ? cyc[0] : 1'b0);
        ins_ready      = ins_rdy;
        redirect       = rd;
        redirect_pc    = rpc;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;

        chk("req_valid", imem_req_valid, (pend.size() + exp_q.size()) < 4);
        if (imem_req_valid) chk("req_addr", imem_req_addr, next_fetch);
        chk("ins_valid", ins_valid, exp_q.size() != 0);
        if (ins_valid && exp_q.size() != 0) begin
            e = exp_q[0];
            chk("ins_pc", ins_pc, e[39:32]);
            chk("ins_data", ins_data, e[31:0]);
        end

        accept = imem_req_valid && imem_req_ready;
        if (accept) begin
            pend.push_back('{addr: next_fetch, due: cyc + lat, ep: epoch});
            next_fetch = next_fetch + 8'd4;
        end
        if (ins_valid && ins_ready && !rd && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            pop_log.push_back(e[39:32]);
            pops++;
        end
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            r = pend.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(r.addr);
            if (r.ep == epoch && !rd) exp_q.push_back({r.addr, mem_word(r.addr)});
        end
        if (rd) begin
            exp_q.delete();
            epoch++;
            next_fetch = {rpc[7:2], 2'b00};
        end
    endtask

    initial begin
        // Reset, then free-run with single-cycle memory
        do_reset(3);
        lat = 1; rdy_pat = 0; ins_rdy = 1'b1;
        pop_log.delete();
        repeat (6) cycle();
        pops = 0;
        repeat (16) cycle();
        chk("throughput", pops, 16);
        chk("free_n", pop_log.size() >= 3, 1);
        if (pop_log.size() >= 3) begin
            chk("free_pc0", pop_log[0], 8'h00);
            chk("free_pc1", pop_log[1], 8'h04);
            chk("free_pc2", pop_log[2], 8'h08);
        end

        // Backpressure: FIFO fills, requests stop after four
        do_reset(2);
        ins_rdy = 1'b0;
        repeat (12) cycle();
        chk("bp_req_valid", imem_req_valid, 0);
        chk("bp_addr", imem_req_addr, 8'h10);
        chk("bp_head_pc", ins_pc, 8'h00);
        chk("bp_ins_valid", ins_valid, 1);
        ins_rdy = 1'b1;
        pop_log.delete();
        repeat (12) cycle();
        chk("bp_resume_n", pop_log.size() >= 5, 1);
        if (pop_log.size() >= 5) chk("bp_resume_pc", pop_log[4], 8'h10);

        // Memory stall with late responses
        rdy_pat = 1; lat = 3;
        repeat (30) cycle();
        ins_rdy = 1'b0;
        repeat (8) cycle();
        ins_rdy = 1'b1;
        repeat (10) cycle();

        // Redirect with traffic in flight
        rdy_pat = 0; lat = 2;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (pend.size() == 2) break;
        end
        cycle(1'b1, 8'h43);
        ins_rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (ins_valid) break;
        end
        chk("redir_seen", ins_valid, 1);
        chk("redir_pc", ins_pc, 8'h40);
        chk("redir_data", ins_data, mem_word(8'h40));
        ins_rdy = 1'b1;
        repeat (8) cycle();

        // Wrap-around of the PC
        lat = 1;
        cycle(1'b1, 8'hF8);
        pop_log.delete();
        repeat (12) cycle();
        chk("wrap_n", pop_log.size() >= 4, 1);
        if (pop_log.size() >= 4) begin
            chk("wrap_pc0", pop_log[0], 8'hF8);
            chk("wrap_pc1", pop_log[1], 8'hFC);
            chk("wrap_pc2", pop_log[2], 8'h00);
            chk("wrap_pc3", pop_log[3], 8'h04);
        end

        // Reset in the middle of a fill
        lat = 2; ins_rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (exp_q.size() >= 3 && pend.size() >= 1) break;
        end
        do_reset(1);
        lat = 1; ins_rdy = 1'b1;
        cycle();
        chk("mid_rst_ins_valid", ins_valid, 0);
        chk("mid_rst_addr", imem_req_addr, 8'h00);
        pop_log.delete();
        repeat (10) cycle();
        chk("mid_rst_n", pop_log.size() >= 1, 1);
        if (pop_log.size() >= 1) chk("mid_rst_pc0", pop_log[0], 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
